// File: rtl/seq_divider16by8_if.sv
// ----------------------------------------------------------------------------
// seq_divider16by8_if
//   Handshake bundle for the 16-by-8 sequential divider.
//   Operand side : in_valid / in_ready / dividend / divisor
//   Result side  : out_valid / out_ready / quotient / remainder / div_by_zero
//   master : the producer/consumer talking to the divider
//   slave  : the divider itself
// ----------------------------------------------------------------------------
interface seq_divider16by8_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider16by8.sv
// ----------------------------------------------------------------------------
// seq_divider16by8
//   Radix-2 restoring divider: unsigned DW-bit dividend / VW-bit divisor,
//   one quotient bit per clock. A divisor of zero skips the iterations and
//   returns quotient = all ones, remainder = dividend[VW-1:0], div_by_zero = 1.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seq_divider16by8_if (operand and result handshakes)
// All interface outputs come straight from flops.
// ----------------------------------------------------------------------------
module seq_divider16by8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input logic               clk,
  input logic               rst_n,
  seq_divider16by8_if.slave bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [VW:0]   rem_q, rem_d;        // partial remainder, MSB is the trial sign
  logic [DW-1:0] quo_q, quo_d;        // dividend shifts out, quotient shifts in
  logic [VW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic          accept_s;
  logic          take_s;
  logic          last_s;
  logic [VW:0]   shift_s;
  logic [VW:0]   trial_s;
  logic          qbit_s;
  logic [VW:0]   rem_next_s;
  logic [DW-1:0] quo_next_s;

  assign accept_s = bus.in_valid && in_ready_q;
  assign take_s   = out_valid_q && bus.out_ready;
  assign last_s   = (cnt_q == CW'(DW - 1));

  // One restoring step. The remainder is always below the divisor, so the
  // shifted value fits in VW+1 bits and the trial MSB is a clean sign bit.
  assign shift_s    = (rem_q << 1) | {{VW{1'b0}}, quo_q[DW-1]};
  assign trial_s    = shift_s - {1'b0, dvs_q};
  assign qbit_s     = ~trial_s[VW];
  assign rem_next_s = qbit_s ? trial_s : shift_s;
  assign quo_next_s = {quo_q[DW-2:0], qbit_s};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = (bus.divisor == '0) ? DONE : BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (take_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output and datapath next-value logic
  always_comb begin
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    in_ready_d  = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          quo_d = bus.dividend;
          dvs_d = bus.divisor;
          rem_d = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      BUSY: begin
        rem_d = rem_next_s;
        quo_d = quo_next_s;
        cnt_d = cnt_q + CW'(1);
        if (last_s) begin
          out_valid_d = 1'b1;
          quotient_d  = quo_next_s;
          remainder_d = rem_next_s[VW-1:0];
          dbz_d       = 1'b0;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      DONE: begin
        if (take_s) begin
          out_valid_d = 1'b0;
        end else if (!out_valid_q) begin
          // Only a zero divisor enters DONE without a result: publish it one
          // cycle after the accept, from the still-unshifted dividend.
          out_valid_d = 1'b1;
          quotient_d  = '1;
          remainder_d = quo_q[VW-1:0];
          dbz_d       = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider16by8.md
# seq_divider16by8

Sequential radix-2 restoring divider that computes an unsigned 16-bit by 8-bit quotient and remainder, one quotient bit per clock. It is the inverse-operation companion to the 8x8 Wallace-tree multiplier: products from the multiplier can be divided back to recover an operand, and the pair is checked against each other in the approximate-arithmetic error-analysis flow. Operands and results move through valid/ready handshakes.

## Interface
- DW, 16, dividend and quotient width
- VW, 8, divisor and remainder width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands (high only in IDLE)
- dividend  input  DW  unsigned dividend
- divisor  input  VW  unsigned divisor
- out_valid  output  1  result present and stable
- out_ready  input  1  consumer takes result
- quotient  output  DW  unsigned quotient
- remainder  output  VW  unsigned remainder, always < divisor when divisor != 0
- div_by_zero  output  1  result belongs to a divisor of 0

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture dividend into the quotient shift register, divisor into a divisor register, clear partial remainder (VW+1 bits) and the iteration counter (log2(DW) bits). Go to BUSY, or to DONE when divisor==0.
- BUSY iteration (once per cycle): shift {partial remainder, quotient register} left by 1; trial = partial remainder - {1'b0,divisor}; if trial is non-negative, keep trial and set quotient LSB=1, otherwise restore and set LSB=0. Counter increments. After DW iterations, go to DONE.
- Divide by zero: no iterations. quotient=all ones (16'hFFFF), remainder=dividend[VW-1:0], div_by_zero=1.
- DONE: out_valid=1. quotient, remainder and div_by_zero hold stable until out_valid&&out_ready, then go to IDLE. in_ready=0 in DONE, so there is no same-cycle accept.
- Inputs change while BUSY/DONE: ignored. Captured registers only.
- div_by_zero clears on the next capture.
- All arithmetic is unsigned. The partial remainder is VW+1 bits wide so the trial subtraction sign is the MSB. Every result is exact: quotient*divisor+remainder == dividend.

## Timing
- Reset values: in_ready=1 once rst_n deasserts. During reset: in_ready=0, out_valid=0, quotient=0, remainder=0, div_by_zero=0, state IDLE, counter 0.
- Accept at edge N. Normal result: out_valid rises after edge N+DW (16 cycles latency). Divide-by-zero result: out_valid rises after edge N+1.
- Result leaves on the edge where out_valid&&out_ready. in_ready rises in the following cycle. Minimum back-to-back issue interval is DW+2 cycles.
- Throughput is not pipelined. One operation is in flight at a time.
- rst_n asserted mid-BUSY or mid-DONE: immediate return to reset values. The pending result is discarded and is never presented.
- Outputs are registered. There is no combinational path from inputs to out_valid, quotient or remainder.

## Test plan
- Multiplier inverse: 65025/255 -> q=255 r=0; 5535/45 -> q=123 r=0; 20000/100 -> q=200 r=0; 7225/85 -> q=85 r=0. Each out_valid exactly 16 cycles after accept.
- Boundaries: 65535/1 -> q=65535 r=0; 0/5 -> q=0 r=0; 1000/7 -> q=142 r=6; 254/255 -> q=0 r=254.
- Divide by zero: 300/0 -> q=16'hFFFF r=44 div_by_zero=1 after 1 cycle. The next op, 10/3, -> q=3 r=1 with div_by_zero=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Outputs stay stable and in_ready stays 0. Operands changing during BUSY do not affect the result.
- Reset mid-operation: assert rst_n=0 at iteration 8 of 40000/200, then release and issue 40000/200. Outputs are reset values during reset, then q=200 r=0 with no stale out_valid.
- Random: 1000 random pairs with nonzero divisor, out_ready randomly toggled. Every result satisfies q*d+r==dividend and r<d.
